dmem_port_arbiter: RTL
======================

Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port between two requesters:
  - the pipeline MEM stage (CPU side);
  - an external master (debug loader / DMA, EXT side).
- Sits between the MEM stage/external master and the DMEM macro.
- Handles priority, bounded EXT bursts and starvation avoidance.
- Routes 1-cycle-latency read data back to whichever requester issued the read.

Parameters:
- DATA_WIDTH, 32, data/address width.
- BURST_MAX, 4, maximum consecutive EXT beats per ownership.
- STARVE_MAX, 8, cycles EXT may wait with a pending request before it is forced ahead of CPU.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cpu_req_i  in  1  CPU access request
- cpu_we_i  in  1  1=store, 0=load
- cpu_addr_i  in  DATA_WIDTH  byte address; bits [1:0] ignored
- cpu_wdata_i  in  DATA_WIDTH  pre-aligned store data
- cpu_be_i  in  4  byte enables for stores
- cpu_gnt_o  out  1  CPU beat accepted this cycle
- cpu_stall_o  out  1  cpu_req_i & ~cpu_gnt_o
- cpu_rvalid_o  out  1  CPU read data valid
- cpu_rdata_o  out  DATA_WIDTH  CPU read data
- ext_req_i, ext_we_i, ext_addr_i, ext_wdata_i, ext_be_i  in  (widths as CPU)  EXT request
- ext_last_i  in  1  final beat of an EXT burst
- ext_gnt_o, ext_rvalid_o, ext_rdata_o  out  (widths as CPU)  EXT response
- DMEM_en_o  out  1  memory access enable
- DMEM_we_o  out  1  memory write enable
- DMEM_add_o  out  DATA_WIDTH  word address {addr[31:2],2'b0}
- DMEM_data_write_o  out  DATA_WIDTH  store data
- DMEM_byte_mark_o  out  4  byte enables; 4'b0 unless DMEM_we_o
- DMEM_data_i  in  DATA_WIDTH  read data, valid the cycle after the read command

Behaviour:
- FSM states: IDLE, CPU_OWN, EXT_BURST. Registered; reset state IDLE.
- Grant rules (combinational from current state and requests; at most one grant per cycle):
  - IDLE/CPU_OWN, starve_cnt<STARVE_MAX: CPU wins if cpu_req_i, else EXT wins if ext_req_i.
  - IDLE/CPU_OWN, starve_cnt==STARVE_MAX and ext_req_i: EXT wins even if cpu_req_i.
  - EXT_BURST: EXT granted if ext_req_i; CPU stalled.
- Transitions:
  - EXT granted with ext_last_i=0 and beat_cnt+1<BURST_MAX -> EXT_BURST.
  - EXT granted with ext_last_i=1, or beat_cnt reaches BURST_MAX -> CPU_OWN if cpu_req_i, else IDLE.
  - In EXT_BURST with ext_req_i=0 (bubble): no grant, hold state, beat_cnt unchanged.
  - CPU granted -> CPU_OWN. No request -> IDLE.
- beat_cnt: clog2(BURST_MAX+1) bits. Cleared on leaving EXT_BURST; +1 per EXT grant.
- starve_cnt:
  - Increments each cycle ext_req_i=1 and ext_gnt_o=0.
  - Saturates at STARVE_MAX.
  - Cleared on any EXT grant.
- Memory command outputs are combinational mux of the granted requester, same cycle as grant.
  - With no grant: DMEM_en_o=0, DMEM_we_o=0, byte_mark=0, address/data hold 0.
- Read return tracking:
  - rd_pend and rd_owner are registered on any read grant.
  - The cycle after a read grant: the owner's rvalid_o=1 and its rdata_o=DMEM_data_i. The other requester's rdata_o=0, rvalid_o=0.
  - Back-to-back reads from alternating owners route correctly (pipelined, one pending max).
  - Writes produce no rvalid.
- Reset (async, rst=1), all immediate:
  - State IDLE; counters 0; rd_pend=0.
  - All grants, rvalids, DMEM_en_o, DMEM_we_o = 0; all data/address outputs 0.
  - A read granted in the cycle before reset yields no rvalid after reset.
- Simultaneous events:
  - cpu_req_i and ext_req_i in the same cycle at starve_cnt<STARVE_MAX -> CPU.
  - ext_last_i with BURST_MAX reached -> single exit, no extra beat.

Test Plan:
- Only CPU: LW @0x104 with mem[0x104]=0xDEADBEEF -> cpu_gnt_o same cycle; DMEM_add_o=0x104; cpu_rvalid_o next cycle with 0xDEADBEEF; stalls 0.
- CPU stores every cycle, EXT req constant -> EXT gets zero grants for 8 cycles. On 9th cycle ext_gnt_o=1, cpu_stall_o=1; starve_cnt then 0.
- EXT 6-beat burst (ext_last_i on 6th), CPU idle, BURST_MAX=4 -> 4 grants, one cycle in IDLE/CPU_OWN, then EXT resumes remaining 2 beats.
- Alternating grants CPU read @0x10, EXT read @0x20 in consecutive cycles -> cpu_rvalid_o then ext_rvalid_o on successive cycles with correct data; no cross-routing.
- EXT SB byte_mark 4'b0100 write -> DMEM_we_o=1, DMEM_byte_mark_o=4'b0100; read grant -> byte_mark 4'b0000.
- Assert rst mid-burst with a read pending -> all outputs 0 immediately; no rvalid after release; next request serviced from IDLE.

Source files
------------

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the CPU, EXT and DMEM signals around the data-memory port arbiter.
// master = requesters and memory macro side, slave = arbiter.
interface dmem_port_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  cpu_req_i;
  logic                  cpu_we_i;
  logic [DATA_WIDTH-1:0] cpu_addr_i;
  logic [DATA_WIDTH-1:0] cpu_wdata_i;
  logic [3:0]            cpu_be_i;
  logic                  cpu_gnt_o;
  logic                  cpu_stall_o;
  logic                  cpu_rvalid_o;
  logic [DATA_WIDTH-1:0] cpu_rdata_o;

  logic                  ext_req_i;
  logic                  ext_we_i;
  logic [DATA_WIDTH-1:0] ext_addr_i;
  logic [DATA_WIDTH-1:0] ext_wdata_i;
  logic [3:0]            ext_be_i;
  logic                  ext_last_i;
  logic                  ext_gnt_o;
  logic                  ext_rvalid_o;
  logic [DATA_WIDTH-1:0] ext_rdata_o;

  logic                  DMEM_en_o;
  logic                  DMEM_we_o;
  logic [DATA_WIDTH-1:0] DMEM_add_o;
  logic [DATA_WIDTH-1:0] DMEM_data_write_o;
  logic [3:0]            DMEM_byte_mark_o;
  logic [DATA_WIDTH-1:0] DMEM_data_i;

  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, cpu_be_i,
    input  cpu_gnt_o, cpu_stall_o, cpu_rvalid_o, cpu_rdata_o,
    output ext_req_i, ext_we_i, ext_addr_i, ext_wdata_i, ext_be_i, ext_last_i,
    input  ext_gnt_o, ext_rvalid_o, ext_rdata_o,
    input  DMEM_en_o, DMEM_we_o, DMEM_add_o, DMEM_data_write_o, DMEM_byte_mark_o,
    output DMEM_data_i
  );

  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, cpu_be_i,
    output cpu_gnt_o, cpu_stall_o, cpu_rvalid_o, cpu_rdata_o,
    input  ext_req_i, ext_we_i, ext_addr_i, ext_wdata_i, ext_be_i, ext_last_i,
    output ext_gnt_o, ext_rvalid_o, ext_rdata_o,
    output DMEM_en_o, DMEM_we_o, DMEM_add_o, DMEM_data_write_o, DMEM_byte_mark_o,
    input  DMEM_data_i
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares one DMEM port between the CPU MEM stage and an external master, with
// bounded EXT bursts, EXT starvation avoidance and 1-cycle read-return routing.
module dmem_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int BURST_MAX  = 4,
  parameter int STARVE_MAX = 8
) (
  input logic               clk,
  input logic               rst,
  dmem_port_arbiter_if.slave bus
);
  localparam int BEAT_W   = $clog2(BURST_MAX + 1);
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, CPU_OWN, EXT_BURST} state_t;

  state_t              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d, beat_inc;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                starved;
  logic                cpu_gnt, ext_gnt;
  logic                rd_pend_q, rd_owner_q;
  logic                cpu_rvalid, ext_rvalid;
  logic [1:0]          unused_addr_bits;

  assign unused_addr_bits = bus.cpu_addr_i[1:0] ^ bus.ext_addr_i[1:0];
  assign starved = (starve_q == STARVE_W'(STARVE_MAX));

  // Grants are gated by rst so the port goes quiet the moment reset asserts.
  always_comb begin
    cpu_gnt = 1'b0;
    ext_gnt = 1'b0;
    if (!rst) begin
      if (state_q == EXT_BURST)               ext_gnt = bus.ext_req_i;
      else if (starved && bus.ext_req_i)      ext_gnt = 1'b1;
      else if (bus.cpu_req_i)                 cpu_gnt = 1'b1;
      else if (bus.ext_req_i)                 ext_gnt = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    beat_inc = beat_q + 1'b1;
    if (ext_gnt) begin
      if (!bus.ext_last_i && (beat_inc < BEAT_W'(BURST_MAX))) begin
        state_d = EXT_BURST;
        beat_d  = beat_inc;
      end else begin
        state_d = bus.cpu_req_i ? CPU_OWN : IDLE;
        beat_d  = '0;
      end
    end else if (state_q != EXT_BURST) begin
      state_d = cpu_gnt ? CPU_OWN : IDLE;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (ext_gnt)                        starve_d = '0;
    else if (bus.ext_req_i && !starved) starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      starve_q   <= '0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      starve_q   <= starve_d;
      rd_pend_q  <= (cpu_gnt && !bus.cpu_we_i) || (ext_gnt && !bus.ext_we_i);
      rd_owner_q <= ext_gnt;
    end
  end

  always_comb begin
    bus.DMEM_en_o         = 1'b0;
    bus.DMEM_we_o         = 1'b0;
    bus.DMEM_add_o        = '0;
    bus.DMEM_data_write_o = '0;
    bus.DMEM_byte_mark_o  = '0;
    if (cpu_gnt) begin
      bus.DMEM_en_o         = 1'b1;
      bus.DMEM_we_o         = bus.cpu_we_i;
      bus.DMEM_add_o        = {bus.cpu_addr_i[DATA_WIDTH-1:2], 2'b00};
      bus.DMEM_data_write_o = bus.cpu_wdata_i;
      bus.DMEM_byte_mark_o  = bus.cpu_we_i ? bus.cpu_be_i : 4'b0000;
    end else if (ext_gnt) begin
      bus.DMEM_en_o         = 1'b1;
      bus.DMEM_we_o         = bus.ext_we_i;
      bus.DMEM_add_o        = {bus.ext_addr_i[DATA_WIDTH-1:2], 2'b00};
      bus.DMEM_data_write_o = bus.ext_wdata_i;
      bus.DMEM_byte_mark_o  = bus.ext_we_i ? bus.ext_be_i : 4'b0000;
    end
  end

  assign cpu_rvalid       = rd_pend_q && !rd_owner_q;
  assign ext_rvalid       = rd_pend_q && rd_owner_q;
  assign bus.cpu_gnt_o    = cpu_gnt;
  assign bus.ext_gnt_o    = ext_gnt;
  assign bus.cpu_stall_o  = bus.cpu_req_i && !cpu_gnt;
  assign bus.cpu_rvalid_o = cpu_rvalid;
  assign bus.ext_rvalid_o = ext_rvalid;
  assign bus.cpu_rdata_o  = cpu_rvalid ? bus.DMEM_data_i : '0;
  assign bus.ext_rdata_o  = ext_rvalid ? bus.DMEM_data_i : '0;
endmodule
